// File: rtl/mat_mult_host_ctrl_if.sv
// Sample, multiplier and result buses between the host controller and its neighbours.
// The master modport is the controller's view; slave is the environment's view.
interface mat_mult_host_ctrl_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_a;
  logic [31:0] s_b;

  logic [31:0] mm_a;
  logic [31:0] mm_b;
  logic [31:0] mm_index;
  logic [31:0] mm_sumout;

  logic        r_valid;
  logic        r_ready;
  logic [31:0] r_data;
  logic [4:0]  r_addr;

  modport master (
    input  s_valid, s_a, s_b, mm_sumout, r_ready,
    output s_ready, mm_a, mm_b, mm_index, r_valid, r_data, r_addr
  );

  modport slave (
    output s_valid, s_a, s_b, mm_sumout, r_ready,
    input  s_ready, mm_a, mm_b, mm_index, r_valid, r_data, r_addr
  );
endinterface

// File: rtl/mat_mult_host_ctrl.sv
// Host-side driver for the complex matrix multiplier: streams (a,b) pairs in with a
// 1-based index, waits out the accumulation, then reads the result buffer back.
module mat_mult_host_ctrl #(
  parameter int N_SAMPLES   = 512,
  parameter int N_RESULTS   = 32,
  parameter int WAIT_CYCLES = 1200,
  parameter int READ_LAT    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  mat_mult_host_ctrl_if.master      bus,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_WAIT, S_RADDR, S_RCAP, S_ROUT, S_DONE
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [4:0]  ptr;

  // NOTE: every register here, outputs included, is state of one FSM and is updated with
  // non-blocking assignments only, so all of them see the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      ptr          <= '0;
      bus.s_ready  <= 1'b0;
      bus.mm_a     <= '0;
      bus.mm_b     <= '0;
      bus.mm_index <= '0;
      bus.r_valid  <= 1'b0;
      bus.r_data   <= '0;
      bus.r_addr   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          bus.mm_index <= '0;
          if (start) begin
            bus.s_ready <= 1'b1;
            busy        <= 1'b1;
            state       <= S_LOAD;
          end
        end

        // The multiplier writes on index change, so index advances once per accepted pair.
        S_LOAD: begin
          if (bus.s_valid && bus.s_ready) begin
            bus.mm_a     <= bus.s_a;
            bus.mm_b     <= bus.s_b;
            bus.mm_index <= bus.mm_index + 32'd1;
            if (bus.mm_index == 32'(N_SAMPLES - 1)) begin
              bus.s_ready <= 1'b0;
              cnt         <= '0;
              state       <= S_SETTLE;
            end
          end
        end

        S_SETTLE: begin
          if (cnt == 32'd1) begin
            cnt   <= '0;
            state <= S_WAIT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        S_WAIT: begin
          if (cnt == 32'(WAIT_CYCLES - 1)) begin
            cnt          <= '0;
            ptr          <= '0;
            bus.mm_index <= '0;
            state        <= S_RADDR;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        // One cycle beyond the read latency covers the index register itself.
        S_RADDR: begin
          bus.mm_index <= 32'(ptr);
          if (cnt == 32'(READ_LAT)) begin
            cnt   <= '0;
            state <= S_RCAP;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        S_RCAP: begin
          bus.r_data  <= bus.mm_sumout;
          bus.r_addr  <= ptr;
          bus.r_valid <= 1'b1;
          state       <= S_ROUT;
        end

        S_ROUT: begin
          if (bus.r_ready) begin
            bus.r_valid <= 1'b0;
            if (ptr == 5'(N_RESULTS - 1)) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              ptr          <= ptr + 5'd1;
              bus.mm_index <= 32'(ptr + 5'd1);
              state        <= S_RADDR;
            end
          end
        end

        S_DONE: begin
          bus.mm_index <= '0;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_mult_host_ctrl.sv
// Scoreboard bench: stimulus pushes the expected index trace and result words into
// queues; independent monitors pop and compare as the controller presents them.
module tb_mat_mult_host_ctrl;
  localparam int N_SAMPLES   = 512;
  localparam int N_RESULTS   = 32;
  localparam int WAIT_CYCLES = 1200;
  localparam int READ_LAT    = 1;
  localparam int FIRST_LAT   = WAIT_CYCLES + 2 + READ_LAT + 2;
  localparam int RES_PERIOD  = READ_LAT + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done;

  mat_mult_host_ctrl_if bus ();

  mat_mult_host_ctrl #(
    .N_SAMPLES(N_SAMPLES), .N_RESULTS(N_RESULTS),
    .WAIT_CYCLES(WAIT_CYCLES), .READ_LAT(READ_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rr_mode = 0;
  int stall_n = 0;
  int t_last  = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc++;

  // Multiplier stand-in: result buffer word i reads back as 1000+i, READ_LAT cycles later.
  logic [31:0] lat_pipe [READ_LAT];
  always @(posedge clk) begin
    lat_pipe[0] <= 32'd1000 + bus.mm_index;
    for (int i = 1; i < READ_LAT; i++) lat_pipe[i] <= lat_pipe[i-1];
  end
  assign bus.mm_sumout = lat_pipe[READ_LAT-1];

  typedef struct {
    logic [31:0] idx;
    logic [31:0] a;
    logic [31:0] b;
    bit          chk_ab;
  } idx_ev_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } res_t;

  idx_ev_t exp_idx[$];
  res_t    exp_res[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected value %0d (t=%0t)", name, act, $time);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_s_ready"},  32'(bus.s_ready), 0);
    check({tag, "_mm_a"},     bus.mm_a, 0);
    check({tag, "_mm_b"},     bus.mm_b, 0);
    check({tag, "_mm_index"}, bus.mm_index, 0);
    check({tag, "_r_valid"},  32'(bus.r_valid), 0);
    check({tag, "_r_data"},   bus.r_data, 0);
    check({tag, "_r_addr"},   32'(bus.r_addr), 0);
    check({tag, "_busy"},     32'(busy), 0);
    check({tag, "_done"},     32'(done), 0);
  endtask

  // Index monitor: every change of mm_index must be the next entry of the expected trace.
  logic [31:0] last_idx = '0;
  always @(negedge clk) begin
    if (!rst) begin
      last_idx = '0;
    end else if (bus.mm_index !== last_idx) begin
      if (exp_idx.size() == 0) begin
        flag("idx_unexpected_change", bus.mm_index);
      end else begin
        idx_ev_t e;
        e = exp_idx.pop_front();
        check("mm_index", bus.mm_index, e.idx);
        if (e.chk_ab) begin
          check("mm_a", bus.mm_a, e.a);
          check("mm_b", bus.mm_b, e.b);
          if (e.idx == 32'(N_SAMPLES)) begin
            check("s_ready_fall_at_last", 32'(bus.s_ready), 0);
            t_last = cyc;
          end
        end
      end
      last_idx = bus.mm_index;
    end
  end

  // Result monitor: compares the presented word against the queue head every valid cycle.
  bit prev_valid  = 1'b0;
  bit prev_stall  = 1'b0;
  bit frame_first = 1'b1;
  int t_rise = 0;
  int stalls = 0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_valid  = 1'b0;
      prev_stall  = 1'b0;
      frame_first = 1'b1;
      stalls      = 0;
    end else begin
      if (prev_stall && !bus.r_valid) flag("r_valid_dropped_without_ready", 32'(bus.r_addr));
      if (bus.r_valid) begin
        if (!prev_valid) begin
          if (frame_first) check("first_result_latency", 32'(cyc - t_last), FIRST_LAT);
          else             check("result_gap", 32'(cyc - t_rise), 32'(RES_PERIOD + stalls));
          frame_first = 1'b0;
          t_rise = cyc;
          stalls = 0;
        end
        if (exp_res.size() == 0) begin
          flag("result_unexpected", 32'(bus.r_addr));
        end else begin
          check("r_data", bus.r_data, exp_res[0].data);
          check("r_addr", 32'(bus.r_addr), 32'(exp_res[0].addr));
          if (bus.r_ready) void'(exp_res.pop_front());
          else stalls++;
        end
      end
      if (done) begin
        done_cnt++;
        frame_first = 1'b1;
        check("results_outstanding_at_done", 32'(exp_res.size()), 0);
      end
      prev_valid = bus.r_valid;
      prev_stall = bus.r_valid && !bus.r_ready;
    end
  end

  // Result-side backpressure: 0 = always ready, 1 = hold off result 5 for 10 cycles, 2 = random.
  initial begin
    bus.r_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        1: begin
          if (bus.r_valid && bus.r_addr == 5'd5 && stall_n < 10) begin
            bus.r_ready = 1'b0;
            stall_n++;
          end else begin
            bus.r_ready = 1'b1;
            if (!bus.r_valid || bus.r_addr != 5'd5) stall_n = 0;
          end
        end
        2:       bus.r_ready = 1'($urandom_range(0, 1));
        default: bus.r_ready = 1'b1;
      endcase
    end
  end

  // Load modes: 0 = valid every cycle with a=k, b=-k; 1 = valid pattern 1,0,0,1; 2 = random.
  task automatic load_frame(input int mode, input int stop_at);
    int k = 1;
    int phase = 0;
    int guard = 0;
    logic v;
    logic [31:0] a, b;
    while (k <= stop_at && guard < 8 * N_SAMPLES) begin
      @(posedge clk); #1;
      guard++;
      case (mode)
        0:       v = 1'b1;
        1:       v = (phase % 4 == 0) || (phase % 4 == 3);
        default: v = 1'($urandom_range(0, 1));
      endcase
      phase++;
      a = (mode == 0) ? 32'(k)  : $urandom;
      b = (mode == 0) ? 32'(-k) : $urandom;
      bus.s_valid = v;
      bus.s_a     = a;
      bus.s_b     = b;
      if (v && bus.s_ready) begin
        exp_idx.push_back('{idx: 32'(k), a: a, b: b, chk_ab: 1'b1});
        k++;
      end
    end
    if (k <= stop_at) check("load_progress_timeout", 32'(k), 32'(stop_at + 1));
    if (stop_at == N_SAMPLES) begin
      for (int p = 0; p < N_RESULTS; p++) begin
        exp_idx.push_back('{idx: 32'(p), a: '0, b: '0, chk_ab: 1'b0});
        exp_res.push_back('{addr: 5'(p), data: 32'(1000 + p)});
      end
      exp_idx.push_back('{idx: '0, a: '0, b: '0, chk_ab: 1'b0});
      bus.s_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        check("s_ready_low_after_load", 32'(bus.s_ready), 0);
      end
      bus.s_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    check("s_ready_after_start", 32'(bus.s_ready), 1);
  endtask

  task automatic run_frame(input int lmode, input int rmode);
    int d0;
    bit seen = 1'b0;
    rr_mode = rmode;
    d0 = done_cnt;
    pulse_start();
    load_frame(lmode, N_SAMPLES);
    for (int i = 0; i < WAIT_CYCLES + 16 * N_RESULTS * RES_PERIOD + 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) flag("done_timeout", 32'(bus.mm_index));
    // start during the done cycle must be ignored
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("busy_after_done", 32'(busy), 0);
    check("mm_index_after_done", bus.mm_index, 0);
    check("done_single_cycle", 32'(done), 0);
    repeat (3) @(posedge clk);
    #1;
    check("busy_stays_idle", 32'(busy), 0);
    check("done_pulse_count", 32'(done_cnt - d0), 1);
  endtask

  initial begin
    #200_000_0;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_a     = '0;
    bus.s_b     = '0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    #2 rst = 1'b1;

    run_frame(0, 0);
    run_frame(1, 1);

    // Reset in the middle of a load: everything clears at once, without a clock edge.
    rr_mode = 0;
    pulse_start();
    load_frame(2, 200);
    @(posedge clk); #2;
    check("mid_load_index", bus.mm_index, 200);
    rst = 1'b0;
    #1 check_zero("async_reset");
    exp_idx.delete();
    exp_res.delete();
    bus.s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    run_frame(2, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mat_mult_host_ctrl.md
Name: mat_mult_host_ctrl

Overview:
- Host-side driver for the 4x64 complex matrix multiplier's index/a/b load and readback port.
- Accepts a valid/ready sample stream and drives the multiplier's a, b and index inputs with a 1-based incrementing index until N_SAMPLES is reached.
- Waits a fixed compute interval, then sweeps the read index over the result buffer.
- Returns each sampled sumout word on a valid/ready result stream.

Parameters:
N_SAMPLES, 512, number of (a,b) pairs per frame; index runs 1..N_SAMPLES
N_RESULTS, 32, result words read back; read index runs 0..N_RESULTS-1
WAIT_CYCLES, 1200, cycles between load completion and first readback (covers 16 x 66-cycle accumulations plus margin)
READ_LAT, 1, cycles from mm_index change to valid mm_sumout

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a frame when in IDLE
s_valid  in  1  input sample valid
s_ready  out  1  input sample ready
s_a  in  32  signed z sample
s_b  in  32  signed j sample
mm_a  out  32  to multiplier a
mm_b  out  32  to multiplier b
mm_index  out  32  to multiplier index
mm_sumout  in  32  from multiplier sumout
r_valid  out  1  result valid
r_ready  in  1  result ready
r_data  out  32  captured result word
r_addr  out  5  read index of r_data
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after the last result is accepted

Behaviour:
- Reset (rst=0, async):
  - State forced to IDLE.
  - All outputs 0: s_ready, mm_a, mm_b, mm_index, r_valid, r_data, r_addr, busy, done.
  - Sample counter and wait counter cleared.
- Reset mid-frame:
  - Same as above, effective immediately.
  - No partial-frame state survives.
  - The multiplier must be reset externally on the same rst.
- IDLE:
  - mm_index held 0.
  - start=1 -> LOAD.
  - start is ignored in every other state.
- LOAD:
  - s_ready=1.
  - Each cycle with s_valid&s_ready: mm_a<=s_a, mm_b<=s_b and mm_index<=mm_index+1, all registered together. The multiplier therefore sees a new index exactly once per sample.
  - s_valid=0: mm_index/mm_a/mm_b hold. The multiplier writes only on an index change, so stalls are safe.
  - Acceptance that brings mm_index to N_SAMPLES -> SETTLE, with s_ready deasserted in the same edge.
  - At most N_SAMPLES samples are accepted per frame.
- SETTLE:
  - Holds mm_index=N_SAMPLES for 2 cycles so the multiplier observes index==N_SAMPLES with no pending write, then -> WAIT.
- WAIT:
  - mm_index held at N_SAMPLES.
  - Counter counts WAIT_CYCLES cycles, then -> RADDR with read pointer p=0.
- RADDR:
  - mm_index<=p (zero-extended).
  - Wait READ_LAT+1 cycles (the extra cycle absorbs the index register), then -> RCAP.
- RCAP:
  - r_data<=mm_sumout, r_addr<=p, r_valid<=1, then -> ROUT.
- ROUT:
  - r_data and r_addr stable while r_valid=1 and r_ready=0.
  - On r_valid&r_ready: r_valid<=0.
    - If p==N_RESULTS-1 -> DONE.
    - Else p<=p+1 -> RADDR.
  - Result throughput is therefore 1 word per (READ_LAT+3) cycles with r_ready tied high.
- DONE:
  - done=1 for one cycle.
  - mm_index<=0, then -> IDLE.
- Width rules:
  - mm_index is a 32-bit unsigned counter, never exceeding max(N_SAMPLES, N_RESULTS-1).
  - Data paths pass through unmodified; no arithmetic on a/b/sumout.
- Boundary conditions:
  - s_valid held high through the end of LOAD: the N_SAMPLES+1-th sample is not accepted (s_ready already 0).
  - start asserted together with the done cycle: ignored (not in IDLE).
  - r_ready high continuously: no extra bubbles beyond those listed.

Test Plan:
1. Reset then start, 512 samples with s_valid=1 every cycle, s_a=k, s_b=-k -> mm_index steps 1..512 on consecutive cycles, mm_a equals index value; s_ready falls on the cycle mm_index becomes 512.
2. Same frame with s_valid toggling 1,0,0,1 -> mm_index advances only on accepted cycles, never repeats or skips; total 512 increments.
3. Readback with mm_sumout driven by a model returning 1000+index one cycle after mm_index -> 32 results, r_addr 0..31, r_data 1000..1031; first r_valid exactly WAIT_CYCLES+2+READ_LAT+2 cycles after last acceptance.
4. r_ready low for 10 cycles on result 5 -> r_data=1005 and r_addr=5 held stable throughout; no result lost or duplicated.
5. rst asserted low mid-LOAD (mm_index=200) -> all outputs 0 asynchronously; after release a new start loads from index 1.
6. Full frame end-to-end against the multiplier with identity-like data -> done pulses exactly once, busy low afterward, mm_index=0.
